// File: rtl/multiport_circular_q.sv
// multiport_circular_q
// Circular FIFO placed between fetch and decode/rename. In each cycle it can
// accept 0..ENQ_W entries at the tail and retire 0..DEQ_W entries from the
// head. It reports its exact occupancy, and a flush empties it in one cycle.
// The payload is opaque to the block.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   flush      synchronous clear; behaves the same as rst
//   enq_cnt    number of enq_data lanes to write this cycle (lane 0 first)
//   enq_data   lane i in bits [i*WIDTH +: WIDTH]
//   enq_ok     high when enq_cnt <= free; enqueue happens only when high
//   deq_cnt    number of head entries the consumer takes this cycle
//   deq_data   lane i = entry at head+i; zero when the lane is invalid
//   deq_valid  lane i valid when i < count
//   count      entries currently held
//   free       DEPTH - count
//   empty      count == 0
//   full       count == DEPTH
module multiport_circular_q #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int EW = $clog2(ENQ_W + 1),
  localparam int DW = $clog2(DEQ_W + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [EW-1:0]          enq_cnt,
  input  logic [ENQ_W*WIDTH-1:0] enq_data,
  output logic                   enq_ok,
  input  logic [DW-1:0]          deq_cnt,
  output logic [DEQ_W*WIDTH-1:0] deq_data,
  output logic [DEQ_W-1:0]       deq_valid,
  output logic [CW-1:0]          count,
  output logic [CW-1:0]          free,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    enq_add;
  logic [CW-1:0]    deq_taken;

  assign free  = CW'(DEPTH) - count;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // The space check uses the occupancy at the start of the cycle. A dequeue
  // in the same cycle does not create room for the enqueue.
  assign enq_ok  = (CW'(enq_cnt) <= free);
  assign enq_add = enq_ok ? CW'(enq_cnt) : '0;

  // A dequeue request larger than the occupancy is clipped to what is held.
  assign deq_taken = (CW'(deq_cnt) < count) ? CW'(deq_cnt) : count;

  // Read lanes come from registered state only, so a same-cycle enqueue is
  // never visible. Lanes at or beyond count are forced to zero.
  always_comb begin
    deq_data  = '0;
    deq_valid = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      if (CW'(i) < count) begin
        deq_valid[i]               = 1'b1;
        deq_data[i*WIDTH +: WIDTH] = mem[head + AW'(i)];
      end
    end
  end

  // The storage array has no reset. Stale contents are masked at the output.
  always_ff @(posedge clk) begin
    if (!rst && !flush && enq_ok) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (i < int'(enq_cnt)) begin
          mem[tail + AW'(i)] <= enq_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Pointers wrap naturally modulo DEPTH. Enqueue and dequeue update
  // independently on the same edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + AW'(enq_add);
      head  <= head + AW'(deq_taken);
      count <= count + enq_add - deq_taken;
    end
  end

endmodule

// File: tb/tb_multiport_circular_q.sv
// tb_multiport_circular_q
// Directed bench for multiport_circular_q with its default parameters
// (WIDTH=32, DEPTH=16, ENQ_W=2, DEQ_W=2). The expected values are written by hand.
module tb_multiport_circular_q;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic                clk;
  logic                rst;
  logic                flush;
  logic [1:0]          enq_cnt;
  logic [2*WIDTH-1:0]  enq_data;
  logic                enq_ok;
  logic [1:0]          deq_cnt;
  logic [2*WIDTH-1:0]  deq_data;
  logic [1:0]          deq_valid;
  logic [4:0]          count;
  logic [4:0]          free;
  logic                empty;
  logic                full;

  int errors = 0;
  int checks = 0;

  multiport_circular_q dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_cnt   (enq_cnt),
    .enq_data  (enq_data),
    .enq_ok    (enq_ok),
    .deq_cnt   (deq_cnt),
    .deq_data  (deq_data),
    .deq_valid (deq_valid),
    .count     (count),
    .free      (free),
    .empty     (empty),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int ec, input logic [31:0] l0,
                               input logic [31:0] l1, input int dc,
                               input logic fl);
    enq_cnt  = 2'(ec);
    enq_data = {l1, l0};
    deq_cnt  = 2'(dc);
    flush    = fl;
  endtask

  // Advance one edge, then sample 1 time unit later. The pointer invariant
  // tail == head + count (mod DEPTH) is checked after every edge.
  task automatic tick();
    logic [AW-1:0] exp_tail;
    @(posedge clk);
    #1;
    exp_tail = dut.head + count[AW-1:0];
    checkOutput("ptr_invariant", 64'(dut.tail), 64'(exp_tail));
  endtask

  function automatic logic [31:0] bpVal(input int j);
    return (j < 14) ? 32'(102 + j) : 32'(200 + j - 14);
  endfunction

  initial begin
    rst = 1'b1;
    applyStimulus(2, 32'hAA, 32'hBB, 0, 1'b0);
    tick();
    tick();
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    checkOutput("rst_full", 64'(full), 64'd0);
    checkOutput("rst_free", 64'(free), 64'd16);
    checkOutput("rst_deq_valid", 64'(deq_valid), 64'd0);
    checkOutput("rst_deq_data", deq_data, 64'd0);
    checkOutput("rst_enq_ok", 64'(enq_ok), 64'd1);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1'b0);
    #1;

    // Fill with 1..16, two per cycle.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(2, 32'(2*k+1), 32'(2*k+2), 0, 1'b0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 1'b0);
    #1;
    checkOutput("fill_count", 64'(count), 64'd16);
    checkOutput("fill_full", 64'(full), 64'd1);
    checkOutput("fill_free", 64'(free), 64'd0);
    checkOutput("fill_deq_valid", 64'(deq_valid), 64'd3);
    checkOutput("fill_deq_data", deq_data, {32'd2, 32'd1});
    checkOutput("full_enq_ok_cnt0", 64'(enq_ok), 64'd1);
    applyStimulus(1, 32'h55, 0, 2, 1'b0);
    #1;
    checkOutput("full_enq_ok_cnt1", 64'(enq_ok), 64'd0);

    // Drain in order, two per cycle.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 0, 2, 1'b0);
      #1;
      checkOutput("drain_pair", deq_data, {32'(2*k+2), 32'(2*k+1)});
      tick();
    end
    applyStimulus(0, 0, 0, 0, 1'b0);
    #1;
    checkOutput("drain_empty", 64'(empty), 64'd1);
    checkOutput("drain_count", 64'(count), 64'd0);
    checkOutput("drain_deq_data", deq_data, 64'd0);

    // Back-pressure: bring count to 15 with 101..115.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(2, 32'(101+2*k), 32'(102+2*k), 0, 1'b0);
      tick();
    end
    applyStimulus(1, 32'd115, 0, 0, 1'b0);
    tick();
    checkOutput("bp_count15", 64'(count), 64'd15);
    applyStimulus(2, 32'd200, 32'd201, 1, 1'b0);
    #1;
    checkOutput("bp_enq_ok_low", 64'(enq_ok), 64'd0);
    checkOutput("bp_head_lane0", 64'(deq_data[31:0]), 64'd101);
    tick();
    checkOutput("bp_count14", 64'(count), 64'd14);
    applyStimulus(2, 32'd200, 32'd201, 0, 1'b0);
    #1;
    checkOutput("bp_enq_ok_high", 64'(enq_ok), 64'd1);
    tick();
    checkOutput("bp_count16", 64'(count), 64'd16);
    checkOutput("bp_full", 64'(full), 64'd1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 0, 2, 1'b0);
      #1;
      checkOutput("bp_order", deq_data, {bpVal(2*k+1), bpVal(2*k)});
      tick();
    end
    checkOutput("bp_empty", 64'(empty), 64'd1);

    // Move head/tail from 1 to 15, then straddle the wrap point.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(2, 32'(k), 32'(k), 0, 1'b0);
      tick();
    end
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 0, 0, 2, 1'b0);
      tick();
    end
    checkOutput("wrap_head15", 64'(dut.head), 64'd15);
    applyStimulus(2, 32'hA5A5, 32'h5B5B, 0, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 0, 1'b0);
    #1;
    checkOutput("wrap_mem15", 64'(dut.mem[15]), 64'hA5A5);
    checkOutput("wrap_mem0", 64'(dut.mem[0]), 64'h5B5B);
    checkOutput("wrap_deq_data", deq_data, {32'h5B5B, 32'hA5A5});
    checkOutput("wrap_count", 64'(count), 64'd2);
    applyStimulus(0, 0, 0, 2, 1'b0);
    tick();
    checkOutput("wrap_head1", 64'(dut.head), 64'd1);
    checkOutput("wrap_empty", 64'(empty), 64'd1);

    // Enqueue and dequeue in the same cycle, with the dequeue clipped.
    applyStimulus(1, 32'h77, 0, 0, 1'b0);
    tick();
    applyStimulus(2, 32'h88, 32'h99, 2, 1'b0);
    #1;
    checkOutput("clip_deq_valid", 64'(deq_valid), 64'd1);
    checkOutput("clip_deq_data", deq_data, {32'd0, 32'h77});
    tick();
    applyStimulus(0, 0, 0, 0, 1'b0);
    #1;
    checkOutput("clip_count", 64'(count), 64'd2);
    checkOutput("clip_next_data", deq_data, {32'h99, 32'h88});
    checkOutput("clip_next_valid", 64'(deq_valid), 64'd3);

    // Flush while enqueue and dequeue requests are present.
    applyStimulus(2, 32'h1, 32'h2, 0, 1'b0);
    tick();
    applyStimulus(2, 32'h3, 32'h4, 0, 1'b0);
    tick();
    applyStimulus(1, 32'h5, 0, 0, 1'b0);
    tick();
    checkOutput("flush_pre_count", 64'(count), 64'd7);
    applyStimulus(2, 32'hE1, 32'hE2, 2, 1'b1);
    tick();
    applyStimulus(0, 0, 0, 2, 1'b0);
    #1;
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_empty", 64'(empty), 64'd1);
    checkOutput("flush_deq_valid", 64'(deq_valid), 64'd0);
    checkOutput("flush_deq_data", deq_data, 64'd0);
    tick();
    checkOutput("empty_deq_noop", 64'(count), 64'd0);
    applyStimulus(1, 32'hC0DE, 0, 0, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 0, 1'b0);
    #1;
    checkOutput("post_flush_data", deq_data, {32'd0, 32'hC0DE});
    checkOutput("post_flush_count", 64'(count), 64'd1);
    checkOutput("post_flush_valid", 64'(deq_valid), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
